// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency a/b/c -> d compute unit among NUM_REQ requesters.
// Each requester has at most one op in flight; its result lands in a one-entry response buffer.
module shared_unit_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned B_DEFAULT = 0,
  parameter int unsigned C_DEFAULT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_c,
  input  logic [NUM_REQ-1:0]       i_req_dflt,
  output logic                     o_unit_valid,
  output logic [WIDTH-1:0]         o_unit_a,
  output logic [WIDTH-1:0]         o_unit_b,
  output logic [WIDTH-1:0]         o_unit_c,
  input  logic [WIDTH-1:0]         i_unit_d,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  input  logic [NUM_REQ-1:0]       i_rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0] o_rsp_d,
  output logic                     o_busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] BDflt = WIDTH'(B_DEFAULT);
  localparam logic [WIDTH-1:0] CDflt = WIDTH'(C_DEFAULT);

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    grant_idx;
  logic               accept;

  logic [WIDTH-1:0]   sel_a, sel_b, sel_c;

  logic               unit_valid_q;
  logic [WIDTH-1:0]   unit_a_q, unit_b_q, unit_c_q;
  logic [NUM_REQ-1:0] issue_oh_q;

  logic [LATENCY-1:0] tag_vld_q;
  logic [NUM_REQ-1:0] tag_oh_q [LATENCY];
  logic [NUM_REQ-1:0] capture;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_d_q [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_hs;

  assign elig   = i_req_valid & ~pending_q;
  assign rsp_hs = rsp_valid_q & i_rsp_ready;

  // First eligible requester searching from ptr upward, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned cand;
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (grant == '0 && elig[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = PtrW'(cand);
      end
    end
  end

  assign accept      = |grant;
  assign o_req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign pending_d = (pending_q | grant) & ~rsp_hs;

  // Operand mux driven by the one-hot grant; defaults replace b/c when flagged.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_a = i_req_a[k*WIDTH +: WIDTH];
        sel_b = i_req_dflt[k] ? BDflt : i_req_b[k*WIDTH +: WIDTH];
        sel_c = i_req_dflt[k] ? CDflt : i_req_c[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      unit_valid_q <= 1'b0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      unit_c_q     <= '0;
      issue_oh_q   <= '0;
    end else begin
      unit_valid_q <= accept;
      issue_oh_q   <= grant;
      if (accept) begin
        unit_a_q <= sel_a;
        unit_b_q <= sel_b;
        unit_c_q <= sel_c;
      end
    end
  end

  assign o_unit_valid = unit_valid_q;
  assign o_unit_a     = unit_a_q;
  assign o_unit_b     = unit_b_q;
  assign o_unit_c     = unit_c_q;

  // Tag stage i holds the op issued i+1 cycles ago; the last stage lines up with i_unit_d.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_oh_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= unit_valid_q;
      tag_oh_q[0]  <= issue_oh_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_oh_q[i]  <= tag_oh_q[i-1];
      end
    end
  end

  assign capture = tag_vld_q[LATENCY-1] ? tag_oh_q[LATENCY-1] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        rsp_d_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (capture[k]) begin
          rsp_valid_q[k] <= 1'b1;
          rsp_d_q[k]     <= i_unit_d;
        end else if (rsp_hs[k]) begin
          rsp_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_rsp_d = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_rsp_d[k*WIDTH +: WIDTH] = rsp_d_q[k];
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_busy      = |pending_q;

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Scoreboard bench for shared_unit_arbiter: expectations are queued at accept time and
// checked by an independent monitor when the unit issues or a response handshakes.
module tb_shared_unit_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [N-1:0]   i_req_valid, o_req_ready, i_req_dflt;
  logic [N*W-1:0] i_req_a, i_req_b, i_req_c;
  logic           o_unit_valid;
  logic [W-1:0]   o_unit_a, o_unit_b, o_unit_c;
  logic [W-1:0]   i_unit_d;
  logic [N-1:0]   o_rsp_valid, i_rsp_ready;
  logic [N*W-1:0] o_rsp_d;
  logic           o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3*W-1:0] unit_q [$];
  logic [W-1:0]   rsp_q [N][$];
  int             grant_log [$];
  int             rsp_log [$];
  logic [W-1:0]   u_pipe;

  shared_unit_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .LATENCY  (2),
    .B_DEFAULT(0),
    .C_DEFAULT(1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_c     (i_req_c),
    .i_req_dflt  (i_req_dflt),
    .o_unit_valid(o_unit_valid),
    .o_unit_a    (o_unit_a),
    .o_unit_b    (o_unit_b),
    .o_unit_c    (o_unit_c),
    .i_unit_d    (i_unit_d),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_d     (o_rsp_d),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Two-cycle unit model: d = a + b + c.
  always @(posedge i_clk) begin
    u_pipe   <= o_unit_a + o_unit_b + o_unit_c;
    i_unit_d <= u_pipe;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_req(int k, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic d);
    i_req_a[k*W +: W] = a;
    i_req_b[k*W +: W] = b;
    i_req_c[k*W +: W] = c;
    i_req_dflt[k]     = d;
    i_req_valid[k]    = 1'b1;
  endtask

  // One clock: record accepts and their expected results, then drop accepted valids.
  task automatic tick();
    logic [N-1:0] acc;
    logic [W-1:0] ea, eb, ec;
    @(negedge i_clk);
    acc = i_req_valid & o_req_ready;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        ea = i_req_a[k*W +: W];
        eb = i_req_dflt[k] ? 8'd0 : i_req_b[k*W +: W];
        ec = i_req_dflt[k] ? 8'd1 : i_req_c[k*W +: W];
        unit_q.push_back({ea, eb, ec});
        rsp_q[k].push_back(ea + eb + ec);
        grant_log.push_back(k);
      end
    end
    @(posedge i_clk);
    #1;
    i_req_valid = i_req_valid & ~acc;
  endtask

  task automatic wait_idle();
    int left;
    for (int i = 0; i < 60; i++) begin
      left = unit_q.size();
      for (int k = 0; k < N; k++) left += rsp_q[k].size();
      if (!o_busy && left == 0 && i_req_valid == '0) break;
      tick();
    end
    check("idle_busy", {31'd0, o_busy}, 32'd0);
    check("idle_outstanding", left, 0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_unit_valid) begin
        if (unit_q.size() == 0) check("unit_unexpected_issue", 1, 0);
        else check("unit_operands", {8'd0, o_unit_a, o_unit_b, o_unit_c}, {8'd0, unit_q.pop_front()});
      end
      for (int k = 0; k < N; k++) begin
        if (o_rsp_valid[k] && i_rsp_ready[k]) begin
          if (rsp_q[k].size() == 0) check("rsp_unexpected", k, 32'hffff);
          else check("rsp_data", o_rsp_d[k*W +: W], rsp_q[k].pop_front());
          rsp_log.push_back(k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0;
    i_req_valid = '0; i_req_dflt = '0; i_req_a = '0; i_req_b = '0; i_req_c = '0;
    i_rsp_ready = '1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_unit_valid", {31'd0, o_unit_valid}, 0);
    check("rst_unit_abc", {8'd0, o_unit_a, o_unit_b, o_unit_c}, 0);
    check("rst_rsp_valid", {28'd0, o_rsp_valid}, 0);
    check("rst_rsp_d", o_rsp_d, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    i_rst_n = 1'b1;

    // All four from reset: grants 0,1,2,3 back-to-back, responses in order.
    grant_log.delete(); rsp_log.delete();
    for (int k = 0; k < N; k++) set_req(k, W'(k + 1), W'(10 * k), W'(2), 1'b0);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rr_ready", {28'd0, o_req_ready}, 32'(1 << k));
      tick();
      check("rr_unit_valid", {31'd0, o_unit_valid}, 1);
    end
    wait_idle();
    check("rr_grant_count", grant_log.size(), 4);
    check("rr_rsp_count", rsp_log.size(), 4);
    for (int k = 0; k < N; k++) begin
      if (k < grant_log.size()) check("rr_grant_order", grant_log[k], k);
      if (k < rsp_log.size()) check("rr_rsp_order", rsp_log[k], k);
    end

    // Single request timing: accept, issue next cycle, response 4 cycles after accept.
    set_req(1, 8'd3, 8'd5, 8'd7, 1'b0);
    #1;
    check("single_ready", {28'd0, o_req_ready}, 32'b0010);
    tick();
    check("single_issue_valid", {31'd0, o_unit_valid}, 1);
    check("single_issue_abc", {8'd0, o_unit_a, o_unit_b, o_unit_c}, 32'h030507);
    tick();
    tick();
    check("single_rsp_early", {28'd0, o_rsp_valid}, 0);
    tick();
    check("single_rsp_valid", {28'd0, o_rsp_valid}, 32'b0010);
    check("single_rsp_d", o_rsp_d[1*W +: W], 15);
    wait_idle();

    // Default substitution: b/c replaced by 0/1.
    set_req(2, 8'd4, 8'd9, 8'd9, 1'b1);
    #1;
    tick();
    check("dflt_issue_abc", {8'd0, o_unit_a, o_unit_b, o_unit_c}, 32'h040001);
    wait_idle();

    // Fairness: after grant to 2, requester 3 wins over 0.
    set_req(2, 8'd1, 8'd2, 8'd3, 1'b0);
    #1;
    check("fair_first", {28'd0, o_req_ready}, 32'b0100);
    tick();
    set_req(0, 8'd7, 8'd0, 8'd0, 1'b0);
    set_req(3, 8'd8, 8'd0, 8'd0, 1'b0);
    #1;
    check("fair_second", {28'd0, o_req_ready}, 32'b1000);
    tick();
    check("fair_third", {28'd0, o_req_ready}, 32'b0001);
    wait_idle();

    // Backpressure on requester 0: held response, no re-grant, others served.
    i_rsp_ready = 4'b1110;
    set_req(0, 8'd10, 8'd20, 8'd30, 1'b0);
    for (int i = 0; i < 10 && !o_rsp_valid[0]; i++) tick();
    check("bp_rsp_valid", {31'd0, o_rsp_valid[0]}, 1);
    set_req(0, 8'd1, 8'd1, 8'd1, 1'b0);
    set_req(1, 8'd2, 8'd3, 8'd4, 1'b0);
    set_req(2, 8'd5, 8'd5, 8'd5, 1'b1);
    #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", {31'd0, o_rsp_valid[0]}, 1);
      check("bp_hold_data", o_rsp_d[0 +: W], 60);
      check("bp_no_regrant", {31'd0, o_req_ready[0]}, 0);
      tick();
    end
    check("bp_others_served", rsp_q[1].size() + rsp_q[2].size(), 0);
    i_rsp_ready = 4'b1111;
    wait_idle();

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) set_req(k, 8'd9, 8'd9, 8'd9, 1'b0);
    repeat (3) tick();
    i_rst_n = 1'b0;
    i_req_valid = '0;
    #1;
    check("mid_rst_busy", {31'd0, o_busy}, 0);
    check("mid_rst_unit_valid", {31'd0, o_unit_valid}, 0);
    unit_q.delete();
    for (int k = 0; k < N; k++) rsp_q[k].delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk);
      #1;
      check("post_rst_rsp_valid", {28'd0, o_rsp_valid}, 0);
      check("post_rst_busy", {31'd0, o_busy}, 0);
    end
    set_req(3, 8'd1, 8'd1, 8'd1, 1'b0);
    set_req(0, 8'd6, 8'd7, 8'd8, 1'b0);
    #1;
    check("post_rst_grant", {28'd0, o_req_ready}, 32'b0001);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
- Shares one fixed-latency three-operand compute unit (operands a/b/c in, result d out) between NUM_REQ requesters.
- Round-robin grant, one issue per cycle, fully pipelined.
- Results return to the issuing requester through a per-requester one-entry response buffer.
- Per-request "use defaults" flag replaces operands b/c with parameterised default values, mirroring port-default semantics at the transaction level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width
- LATENCY, 2, unit latency in cycles from o_unit_valid to i_unit_d valid (>=1)
- B_DEFAULT, 0, value driven on o_unit_b when default flag set
- C_DEFAULT, 1, value driven on o_unit_c when default flag set

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  one-hot grant/accept
- i_req_a  in  NUM_REQ*WIDTH  operand a, requester k at [k*WIDTH+:WIDTH]
- i_req_b  in  NUM_REQ*WIDTH  operand b
- i_req_c  in  NUM_REQ*WIDTH  operand c
- i_req_dflt  in  NUM_REQ  1 = substitute B_DEFAULT/C_DEFAULT for b/c
- o_unit_valid  out  1  issue strobe to unit
- o_unit_a  out  WIDTH  operand a to unit
- o_unit_b  out  WIDTH  operand b to unit
- o_unit_c  out  WIDTH  operand c to unit
- i_unit_d  in  WIDTH  unit result, sampled LATENCY cycles after o_unit_valid
- o_rsp_valid  out  NUM_REQ  response valid
- i_rsp_ready  in  NUM_REQ  response accept
- o_rsp_d  out  NUM_REQ*WIDTH  response data
- o_busy  out  1  any requester pending

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - o_unit_valid/a/b/c = 0, o_rsp_valid = 0, o_rsp_d = 0, o_busy = 0.
  - RR pointer = 0, all pending flags = 0, tag pipeline cleared.
- pending[k]: set on accept of requester k; cleared on response handshake (o_rsp_valid[k] & i_rsp_ready[k]).
- Eligibility: elig[k] = i_req_valid[k] & ~pending[k].
- Grant (combinational, same cycle):
  - First eligible index searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - o_req_ready is one-hot of that index; all zero if none eligible.
  - o_req_ready never depends on i_rsp_ready.
- On accept of requester g at edge t:
  - ptr <= (g+1) mod NUM_REQ.
  - No accept: ptr holds.
- Issue: cycle after accept, registered outputs.
  - o_unit_valid = 1, o_unit_a = a[g].
  - o_unit_b/c = dflt[g] ? B_DEFAULT/C_DEFAULT : b[g]/c[g].
  - o_unit_valid low in cycles without a prior-cycle accept; operand outputs hold their last value.
- Tag pipeline: LATENCY-stage shift of {valid, one-hot requester}.
  - At the edge where the stage-LATENCY entry is valid, i_unit_d is captured into rsp buffer k.
  - o_rsp_valid[k] rises next cycle.
- Total latency, accept edge to o_rsp_valid: LATENCY+2 cycles.
- o_rsp_valid[k] and o_rsp_d[k] are held stable until i_rsp_ready[k]. i_rsp_ready while o_rsp_valid low is ignored.
- The pending flag guarantees at most one in-flight op per requester, so response buffers never overflow. Up to NUM_REQ ops may be in flight.
- Simultaneous response handshake and i_req_valid on the same requester: not eligible that cycle (pending still set); eligible next cycle.
- o_busy = |pending.
- Reset mid-operation: in-flight ops and buffered responses are dropped; no stale response appears after deassertion.
- Default values are truncated/zero-extended to WIDTH.

Test Plan:
- Single request: requester 1, a=3, b=5, c=7, dflt=0, LATENCY=2, bench unit d=a+b+c.
  -> o_req_ready=0010 same cycle.
  -> o_unit_valid next cycle with 3/5/7.
  -> o_rsp_valid[1]=1 with d=15 four cycles after accept.
- All four valid from reset -> accepts in order 0,1,2,3 on consecutive cycles; four issues back-to-back; responses in the same order.
- Defaults: requester 2, a=4, b=9, c=9, dflt=1 -> unit sees 4/0/1; response 5.
- Backpressure: i_rsp_ready[0]=0 for 10 cycles.
  -> o_rsp_valid[0] and data stay stable.
  -> requester 0 is not re-granted while held.
  -> others continue to be served.
- Fairness: after a grant to 2, requesters 0 and 3 both eligible -> 3 granted first, then 0.
- Reset with 3 ops in flight -> after release, o_rsp_valid stays 0, o_busy=0, first new grant goes to requester 0.
